// File: rtl/aes_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_sub_bytes_seq
// Purpose  : Schedules the 16 AES state bytes through a shared pool of masked
//            S-boxes in slices. Slice issue is gated by fresh PRD. Returning
//            slices are tracked with a token pipeline that matches the S-box
//            latency.
// Revision : 1.0 - initial release
// ============================================================================
module aes_sub_bytes_seq #(
  parameter int NumSBoxes   = 4,
  parameter int SBoxLatency = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic       out_req_o,
  input  logic       out_ack_i,
  input  logic       prd_valid_i,
  output logic       prd_update_o,
  output logic       in_valid_o,
  output logic [3:0] in_slice_o,
  output logic       out_we_o,
  output logic [3:0] out_slice_o,
  output logic       busy_o,
  output logic       alert_o
);

  localparam int         NumSlices  = 16 / NumSBoxes;
  localparam logic [4:0] LastSlice  = 5'(NumSlices - 1);
  localparam logic [4:0] SliceCount = 5'(NumSlices);

  generate
    if (!(NumSBoxes == 1 || NumSBoxes == 2 || NumSBoxes == 4 ||
          NumSBoxes == 8 || NumSBoxes == 16)) begin : g_bad_num_sboxes
      $error("NumSBoxes must be 1, 2, 4, 8 or 16");
    end
    if (SBoxLatency < 1 || SBoxLatency > 8) begin : g_bad_sbox_latency
      $error("SBoxLatency must be in 1..8");
    end
  endgenerate

  // Pairwise Hamming distance of at least 3, so that a single flipped bit never
  // turns one legal state into another.
  typedef enum logic [5:0] {
    StIdle  = 6'b000000,
    StIssue = 6'b000111,
    StDrain = 6'b011001,
    StDone  = 6'b101010,
    StError = 6'b110100
  } state_e;

  // The register is held as raw bits so that any corrupted encoding can be
  // represented and is caught by the default branch below.
  logic [5:0]                   state_q;
  state_e                       state_d;
  logic [4:0]                   issue_cnt_q, issue_cnt_d;
  logic [4:0]                   ret_cnt_q, ret_cnt_d;
  logic [SBoxLatency-1:0]       tok_vld_q, tok_vld_d;
  logic [SBoxLatency-1:0][3:0]  tok_slc_q, tok_slc_d;

  logic running;
  logic issue;
  logic tok_exit;
  logic err;

  assign running  = (state_q == StIssue) || (state_q == StDrain);
  assign issue    = (state_q == StIssue) && prd_valid_i;
  assign tok_exit = running && tok_vld_q[SBoxLatency-1];
  assign err      = (ret_cnt_q > issue_cnt_q) || (tok_exit && (issue_cnt_q == 5'd0));

  // Token pipeline: advances every cycle while running, flushed otherwise.
  always_comb begin
    tok_vld_d = '0;
    tok_slc_d = '0;
    if (running && en_i) begin
      tok_vld_d[0] = issue;
      tok_slc_d[0] = issue ? issue_cnt_q[3:0] : 4'd0;
      for (int k = 1; k < SBoxLatency; k++) begin
        tok_vld_d[k] = tok_vld_q[k-1];
        tok_slc_d[k] = tok_slc_q[k-1];
      end
    end
  end

  // Next-state and counter logic; error conditions override everything.
  always_comb begin
    state_d     = StError;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    case (state_q)
      StIdle: begin
        state_d     = en_i ? StIssue : StIdle;
        issue_cnt_d = 5'd0;
        ret_cnt_d   = 5'd0;
      end
      StIssue: begin
        if (!en_i) begin
          state_d     = StIdle;
          issue_cnt_d = 5'd0;
          ret_cnt_d   = 5'd0;
        end else begin
          ret_cnt_d = ret_cnt_q + {4'd0, tok_exit};
          if (issue) begin
            issue_cnt_d = issue_cnt_q + 5'd1;
          end
          state_d = (issue && (issue_cnt_q == LastSlice)) ? StDrain : StIssue;
        end
      end
      StDrain: begin
        if (!en_i) begin
          state_d     = StIdle;
          issue_cnt_d = 5'd0;
          ret_cnt_d   = 5'd0;
        end else begin
          ret_cnt_d = ret_cnt_q + {4'd0, tok_exit};
          state_d   = (tok_exit && ((ret_cnt_q + 5'd1) == SliceCount)) ? StDone : StDrain;
        end
      end
      StDone: begin
        state_d = (!en_i || out_ack_i) ? StIdle : StDone;
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StError;
      end
    endcase
    if (err) begin
      state_d = StError;
    end
  end

  // State, counters and token pipeline registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      issue_cnt_q <= 5'd0;
      ret_cnt_q   <= 5'd0;
      tok_vld_q   <= '0;
      tok_slc_q   <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      tok_vld_q   <= tok_vld_d;
      tok_slc_q   <= tok_slc_d;
    end
  end

  // Outputs decode only from registered state plus the same-cycle PRD/enable qualifiers.
  assign in_valid_o   = issue;
  assign prd_update_o = issue;
  assign in_slice_o   = (state_q == StIssue) ? issue_cnt_q[3:0] : 4'd0;
  assign out_we_o     = tok_exit && en_i && !err;
  assign out_slice_o  = out_we_o ? tok_slc_q[SBoxLatency-1] : 4'd0;
  assign out_req_o    = (state_q == StDone);
  assign busy_o       = (state_q != StIdle);
  assign alert_o      = (state_q == StError);

endmodule
`default_nettype wire

// File: tb/tb_aes_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_sub_bytes_seq
// Purpose  : Directed bench for aes_sub_bytes_seq: nominal, PRD stall, abort,
//            back-to-back, parameter sweep and state-corruption scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_sub_bytes_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: default parameters
  logic       en0 = 1'b0, ack0 = 1'b0, prd0 = 1'b1;
  logic       req0, upd0, iv0, we0, busy0, al0;
  logic [3:0] isl0, osl0;
  // Instance 1: 16 S-boxes, latency 1
  logic       en1 = 1'b0, ack1 = 1'b0, prd1 = 1'b1;
  logic       req1, upd1, iv1, we1, busy1, al1;
  logic [3:0] isl1, osl1;
  // Instance 2: 1 S-box, latency 8
  logic       en2 = 1'b0, ack2 = 1'b0, prd2 = 1'b1;
  logic       req2, upd2, iv2, we2, busy2, al2;
  logic [3:0] isl2, osl2;

  aes_sub_bytes_seq #(.NumSBoxes(4), .SBoxLatency(5)) dut0 (
    .clk_i(clk), .rst_i(rst), .en_i(en0), .out_req_o(req0), .out_ack_i(ack0),
    .prd_valid_i(prd0), .prd_update_o(upd0), .in_valid_o(iv0), .in_slice_o(isl0),
    .out_we_o(we0), .out_slice_o(osl0), .busy_o(busy0), .alert_o(al0));

  aes_sub_bytes_seq #(.NumSBoxes(16), .SBoxLatency(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en1), .out_req_o(req1), .out_ack_i(ack1),
    .prd_valid_i(prd1), .prd_update_o(upd1), .in_valid_o(iv1), .in_slice_o(isl1),
    .out_we_o(we1), .out_slice_o(osl1), .busy_o(busy1), .alert_o(al1));

  aes_sub_bytes_seq #(.NumSBoxes(1), .SBoxLatency(8)) dut2 (
    .clk_i(clk), .rst_i(rst), .en_i(en2), .out_req_o(req2), .out_ack_i(ack2),
    .prd_valid_i(prd2), .prd_update_o(upd2), .in_valid_o(iv2), .in_slice_o(isl2),
    .out_we_o(we2), .out_slice_o(osl2), .busy_o(busy2), .alert_o(al2));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_dut0(input string scn, input logic e_iv, input int e_isl, input logic e_we,
                            input int e_osl, input logic e_req, input logic e_busy, input logic e_al);
    check_eq({scn, ".in_valid"}, 32'(iv0), 32'(e_iv));
    check_eq({scn, ".prd_update"}, 32'(upd0), 32'(e_iv));
    if (e_iv) check_eq({scn, ".in_slice"}, 32'(isl0), 32'(e_isl));
    check_eq({scn, ".out_we"}, 32'(we0), 32'(e_we));
    if (e_we) check_eq({scn, ".out_slice"}, 32'(osl0), 32'(e_osl));
    check_eq({scn, ".out_req"}, 32'(req0), 32'(e_req));
    check_eq({scn, ".busy"}, 32'(busy0), 32'(e_busy));
    check_eq({scn, ".alert"}, 32'(al0), 32'(e_al));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      en0 = 1'b0; ack0 = 1'b0; prd0 = 1'b1;
      en1 = 1'b0; ack1 = 1'b0; prd1 = 1'b1;
      en2 = 1'b0; ack2 = 1'b0; prd2 = 1'b1;
    end
  endtask

  // mode 0 nominal, 1 PRD stall, 2 abort at cycle 7, 3 back-to-back
  task automatic run_dut0(input int mode);
    string scn;
    logic  e_iv, e_we, e_req, e_busy;
    int    e_isl, e_osl, last;
    scn  = (mode == 0) ? "nominal" : (mode == 1) ? "stall" : (mode == 2) ? "abort" : "b2b";
    last = (mode == 3) ? 14 : 13;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      cyc  = c;
      en0  = (mode == 3) ? 1'b1 : (mode == 2) ? (c <= 6) : (c <= 12);
      prd0 = !(mode == 1 && (c == 2 || c == 3));
      ack0 = (c == 12) || (mode == 0 && c == 3);
      #1;
      e_iv   = (c >= 1 && c <= 4);
      e_isl  = c - 1;
      e_we   = (c >= 6 && c <= 9);
      e_osl  = c - 6;
      e_req  = (c >= 10 && c <= 12);
      e_busy = (c >= 1 && c <= 12);
      if (mode == 1) begin
        e_iv  = (c == 1) || (c >= 4 && c <= 6);
        e_isl = (c == 1) ? 0 : c - 3;
        e_we  = (c == 6) || (c >= 9 && c <= 11);
        e_osl = (c == 6) ? 0 : c - 8;
        e_req = (c == 12);
      end
      if (mode == 2) begin
        e_we   = (c == 6);
        e_req  = 1'b0;
        e_busy = (c >= 1 && c <= 7);
      end
      if (mode == 3) begin
        e_iv   = e_iv || (c == 14);
        e_isl  = (c == 14) ? 0 : c - 1;
        e_busy = e_busy || (c == 14);
      end
      check_dut0(scn, e_iv, e_isl, e_we, e_osl, e_req, e_busy, 1'b0);
    end
  endtask

  task automatic run_dut1();
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk); #1;
      cyc = c;
      en1 = (c <= 4); ack1 = (c == 4); prd1 = 1'b1;
      #1;
      check_eq("ns16.in_valid", 32'(iv1), 32'(c == 1));
      if (c == 1) check_eq("ns16.in_slice", 32'(isl1), 32'd0);
      check_eq("ns16.out_we", 32'(we1), 32'(c == 2));
      if (c == 2) check_eq("ns16.out_slice", 32'(osl1), 32'd0);
      check_eq("ns16.out_req", 32'(req1), 32'(c >= 3 && c <= 4));
      check_eq("ns16.busy", 32'(busy1), 32'(c >= 1 && c <= 4));
      check_eq("ns16.alert", 32'(al1), 32'd0);
    end
  endtask

  task automatic run_dut2();
    for (int c = 0; c <= 26; c++) begin
      @(posedge clk); #1;
      cyc = c;
      en2 = (c <= 25); ack2 = (c == 25); prd2 = 1'b1;
      #1;
      check_eq("ns1.in_valid", 32'(iv2), 32'(c >= 1 && c <= 16));
      if (c >= 1 && c <= 16) check_eq("ns1.in_slice", 32'(isl2), 32'(c - 1));
      check_eq("ns1.out_we", 32'(we2), 32'(c >= 9 && c <= 24));
      if (c >= 9 && c <= 24) check_eq("ns1.out_slice", 32'(osl2), 32'(c - 9));
      check_eq("ns1.out_req", 32'(req2), 32'(c == 25));
      check_eq("ns1.busy", 32'(busy2), 32'(c >= 1 && c <= 25));
    end
  endtask

  task automatic run_fault();
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk); #1;
      cyc  = c;
      en0  = 1'b1; prd0 = 1'b1; ack0 = (c == 8);
      if (c == 2) begin
        force dut0.state_q = 6'b111111;
        #1;
        release dut0.state_q;
      end else begin
        #1;
      end
      if (c >= 2) begin
        check_dut0("fault", 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, (c >= 3));
      end
    end
    @(posedge clk); #1;
    en0 = 1'b0;
    rst = 1'b1;
    #1;
    cyc = -2;
    check_dut0("fault_rst", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("fault_rst.in_slice", 32'(isl0), 32'd0);
    check_eq("fault_rst.out_slice", 32'(osl0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    cyc = -1;
    check_dut0("reset", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("reset.in_slice", 32'(isl0), 32'd0);
    check_eq("reset.out_slice", 32'(osl0), 32'd0);
    check_eq("reset.ns16_busy", 32'(busy1), 32'd0);
    check_eq("reset.ns1_busy", 32'(busy2), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    run_dut0(0);
    idle(2);
    run_dut0(1);
    idle(2);
    run_dut0(2);
    run_dut0(0);
    idle(2);
    run_dut0(3);
    idle(3);
    run_dut1();
    idle(2);
    run_dut2();
    idle(2);
    run_fault();
    idle(2);
    run_dut0(0);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_sub_bytes_seq.md
Name: aes_sub_bytes_seq

Overview:
- Sequences SubBytes over a shared pool of NumSBoxes masked (DOM) S-box instances. Each round, the 16 state bytes pass through the pool in NumSlices = 16/NumSBoxes slices.
- Sits between aes_cipher_control_fsm (sub_bytes_en / out_req / out_ack handshake) and the S-box pool.
- Schedules slice issue gated by fresh PRD and tracks in-flight slices through the fixed-latency S-box pipeline.
- Raises the completion request once all slices have been written back.

Parameters:
- NumSBoxes, 4, number of physical S-box instances; legal values 1, 2, 4, 8, 16; elaboration error otherwise.
- SBoxLatency, 5, S-box pipeline depth in cycles; legal range 1..8.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  sub_bytes_en from cipher control; held high until the handshake completes.
- out_req_o  out  1  all slices done, result valid.
- out_ack_i  in  1  cipher control accepts the result.
- prd_valid_i  in  1  fresh PRD is available for one slice.
- prd_update_o  out  1  consume PRD and request the next value; equals in_valid_o.
- in_valid_o  out  1  issue a slice to the S-box pool this cycle.
- in_slice_o  out  4  index of the issued slice (0..NumSlices-1, zero-extended).
- out_we_o  out  1  pool output is valid; write to the state register.
- out_slice_o  out  4  index of the returned slice.
- busy_o  out  1  state is not IDLE.
- alert_o  out  1  fatal error, sticky.

Behaviour:
- Reset values: state IDLE. All outputs 0. issue_cnt = 0, ret_cnt = 0. Token shift register (SBoxLatency entries of {valid, slice}) cleared.
- States: IDLE, ISSUE, DRAIN, DONE, ERROR. Sparse encoding with Hamming distance ≥ 3. Any unlisted encoding → ERROR.
- IDLE: when en_i = 1, go to ISSUE next cycle. issue_cnt and ret_cnt are cleared.
- ISSUE:
  - in_valid_o = prd_valid_i. in_slice_o = issue_cnt.
  - On an issue, issue_cnt increments and the token {1, issue_cnt} enters the shift register.
  - When the issue with issue_cnt = NumSlices-1 happens, go to DRAIN.
  - prd_valid_i = 0 stalls issue only. In-flight tokens keep advancing every cycle; the pipeline never stalls.
- Return path (ISSUE and DRAIN):
  - A token issued at cycle t exits at t+SBoxLatency.
  - On exit: out_we_o = 1, out_slice_o = token slice, ret_cnt increments.
- DRAIN: when ret_cnt reaches NumSlices (the last out_we_o cycle), go to DONE next cycle.
- DONE: out_req_o = 1 and holds until out_ack_i = 1. On ack, go to IDLE next cycle; out_req_o drops in that IDLE cycle.
- NumSBoxes = 16: one issue, then DRAIN directly.
- Latency with no PRD stall: en_i high at cycle 0 →
  - ISSUE during cycles 1..NumSlices;
  - last out_we_o at NumSlices+SBoxLatency;
  - out_req_o from NumSlices+SBoxLatency+1.
- en_i low in ISSUE or DRAIN (abort):
  - next state IDLE;
  - shift register flushed; out_we_o suppressed from that same cycle;
  - counters cleared; no out_req_o.
- en_i low in DONE: go to IDLE. This also holds when out_ack_i arrives in the same cycle.
- out_ack_i outside DONE: ignored.
- en_i re-asserted in the first IDLE cycle after a handshake: a new operation starts normally.
- Error conditions, each sends the FSM to ERROR:
  - illegal state encoding;
  - ret_cnt > issue_cnt;
  - a token exiting while issue_cnt = 0.
- ERROR:
  - alert_o = 1; in_valid_o, out_we_o and out_req_o forced 0;
  - busy_o = 1;
  - state stays in ERROR until rst_i.
- rst_i asserted at any time: outputs return to their reset values asynchronously.
- Counter widths: 5 bits. Slices never wrap within one operation.

Test Plan:
- Nominal run, defaults, prd_valid_i = 1:
  - en_i at cycle 0 → in_valid_o in cycles 1–4 with slices 0,1,2,3;
  - out_we_o in cycles 6–9 with slices 0–3;
  - out_req_o at cycle 10;
  - out_ack_i at cycle 12 → IDLE at 13, busy_o = 0.
- PRD stall, defaults:
  - prd_valid_i low in cycles 2–3 → issues at cycles 1, 4, 5, 6;
  - out_we_o at cycles 6, 9, 10, 11;
  - out_req_o at cycle 12.
- Abort:
  - en_i dropped at cycle 7 of a nominal run → out_we_o = 0 from cycle 7;
  - IDLE at 8; out_req_o never asserted;
  - the next operation re-issues starting from slice 0.
- Parameter sweep:
  - NumSBoxes = 16, SBoxLatency = 1 → single issue at cycle 1, out_we_o at 2, out_req_o at 3;
  - NumSBoxes = 1, SBoxLatency = 8 → 16 issues, out_req_o at cycle 25.
- Back-to-back: en_i held high through the ack → second operation issues slice 0 one cycle after returning to IDLE.
- Fault: force the state register to an illegal value mid-ISSUE → alert_o = 1 next cycle, sticky; outputs quiet until rst_i pulse.
